// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory (RAM + LED register) between
// the CPU load/store path (m0) and the DMA/boot-loader port (m1).
// The arbiter alternates on ties, supports locked bursts with a hold limit,
// and returns read data registered one cycle after acceptance.
module dmem_arbiter #(
  parameter int MAX_LOCK = 16,
  parameter int CNT_W    = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic        m0_lock,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic        m1_lock,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        lock_timeout,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Address,
  output logic [31:0] Write_data,
  input  logic [31:0] Read_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);

  logic [1:0]       state_q, state_d;
  logic             last_q, last_d;      // 1 = m1 was granted last
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             timeout_q, timeout_d;
  logic             rvalid0_q, rvalid1_q;
  logic [31:0]      rdata0_q, rdata1_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             acc_lock;

  assign cnt_inc = lock_cnt_q + CNT_W'(1);

  // Grant selection: owner-only while locked, alternate on ties when idle.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    case (state_q)
      OWN0:    m0_gnt = m0_req;
      OWN1:    m1_gnt = m1_req;
      default: begin
        if (m0_req && m1_req) begin
          m0_gnt = last_q;
          m1_gnt = ~last_q;
        end else begin
          m0_gnt = m0_req;
          m1_gnt = m1_req;
        end
      end
    endcase
  end

  // Memory drive: route the granted requester, otherwise park everything at zero.
  always_comb begin
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Address    = 32'd0;
    Write_data = 32'd0;
    acc_lock   = 1'b0;
    if (m0_gnt) begin
      MemRead    = ~m0_we;
      MemWrite   = m0_we;
      Address    = m0_addr;
      Write_data = m0_wdata;
      acc_lock   = m0_lock;
    end else if (m1_gnt) begin
      MemRead    = ~m1_we;
      MemWrite   = m1_we;
      Address    = m1_addr;
      Write_data = m1_wdata;
      acc_lock   = m1_lock;
    end
  end

  // Next-state: ownership, tie-break history and lock-hold counting.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    timeout_d  = 1'b0;
    if (m0_gnt || m1_gnt) begin
      last_d = m1_gnt;
      if (acc_lock && (cnt_inc < MAX_CNT)) begin
        state_d    = m1_gnt ? OWN1 : OWN0;
        lock_cnt_d = cnt_inc;
      end else begin
        // Either an unlocked access or the hold limit was reached.
        state_d    = IDLE;
        lock_cnt_d = '0;
        timeout_d  = acc_lock;
      end
    end else if ((state_q == OWN0 && !m0_req && !m0_lock) ||
                 (state_q == OWN1 && !m1_req && !m1_lock)) begin
      state_d    = IDLE;
      lock_cnt_d = '0;
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      lock_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Read return: capture memory data on an accepted read, pulse rvalid next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= 32'd0;
      rdata1_q  <= 32'd0;
    end else begin
      rvalid0_q <= m0_gnt && !m0_we;
      rvalid1_q <= m1_gnt && !m1_we;
      if (m0_gnt && !m0_we) rdata0_q <= Read_data;
      if (m1_gnt && !m1_we) rdata1_q <= Read_data;
    end
  end

  assign m0_rvalid    = rvalid0_q;
  assign m1_rvalid    = rvalid1_q;
  assign m0_rdata     = rdata0_q;
  assign m1_rdata     = rdata1_q;
  assign lock_timeout = timeout_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized traffic for dmem_arbiter,
// checked cycle by cycle against a behavioural arbitration/memory model.
module tb_dmem_arbiter;

  localparam int MAX_LOCK = 16;
  localparam logic [31:0] LED_ADDR = 32'h0000_4000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, lock_timeout;
  logic [31:0] m0_rdata, m1_rdata;
  logic        MemRead, MemWrite;
  logic [31:0] Address, Write_data, Read_data;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_LOCK(MAX_LOCK), .CNT_W(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .lock_timeout(lock_timeout), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .Write_data(Write_data), .Read_data(Read_data)
  );

  function automatic logic [31:0] init_word(int i);
    case (i)
      0:       return 32'h0000_0014;
      1:       return 32'h0000_41a8;
      2:       return 32'h0000_3af2;
      default: return 32'h1000_0000 + 32'(i) * 32'h0000_0101;
    endcase
  endfunction

  // Memory seen by the DUT: 256-word RAM plus the LED register.
  logic [31:0] mem [256];
  logic [31:0] led;
  logic        mem_load;
  assign Read_data = (Address == LED_ADDR) ? led : mem[Address[9:2]];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      led <= 32'd0;
    end else if (MemWrite) begin
      if (Address == LED_ADDR) led <= Write_data;
      else mem[Address[9:2]] <= Write_data;
    end
  end

  // Reference model state.
  logic [31:0] rmem [256];
  logic [31:0] rled;
  int          owner;     // -1 = bus free, else owning requester id
  int          hold;      // grants issued to the current locked burst
  int          last_id;   // requester granted most recently
  bit          e_rv0, e_rv1, e_to;
  logic [31:0] e_rd0, e_rd1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = -1; hold = 0; last_id = 1;
    e_rv0 = 0; e_rv1 = 0; e_to = 0;
    e_rd0 = 32'd0; e_rd1 = 32'd0;
  endtask

  function automatic logic [31:0] ref_read(logic [31:0] a);
    return (a == LED_ADDR) ? rled : rmem[a[9:2]];
  endfunction

  // Which requester should be served this cycle (-1 for none).
  function automatic int expected_winner();
    if (owner == 0) return m0_req ? 0 : -1;
    if (owner == 1) return m1_req ? 1 : -1;
    if (m0_req && m1_req) return (last_id == 0) ? 1 : 0;
    if (m0_req) return 0;
    if (m1_req) return 1;
    return -1;
  endfunction

  // One clock cycle: entered at a negedge with inputs already driven.
  task automatic tick();
    int          g;
    logic        we, lk;
    logic [31:0] a, d;
    #1;
    g  = expected_winner();
    we = (g == 0) ? m0_we : m1_we;
    lk = (g == 0) ? m0_lock : m1_lock;
    a  = (g == 0) ? m0_addr : (g == 1) ? m1_addr : 32'd0;
    d  = (g == 0) ? m0_wdata : (g == 1) ? m1_wdata : 32'd0;
    chk("m0_gnt", 32'(m0_gnt), 32'(g == 0));
    chk("m1_gnt", 32'(m1_gnt), 32'(g == 1));
    chk("MemRead", 32'(MemRead), 32'(g >= 0 && !we));
    chk("MemWrite", 32'(MemWrite), 32'(g >= 0 && we));
    chk("Address", Address, a);
    chk("Write_data", Write_data, d);
    chk("m0_rvalid", 32'(m0_rvalid), 32'(e_rv0));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(e_rv1));
    chk("m0_rdata", m0_rdata, e_rd0);
    chk("m1_rdata", m1_rdata, e_rd1);
    chk("lock_timeout", 32'(lock_timeout), 32'(e_to));
    e_rv0 = 0; e_rv1 = 0; e_to = 0;
    if (g >= 0) begin
      last_id = g;
      if (!we) begin
        if (g == 0) begin e_rv0 = 1; e_rd0 = ref_read(a); end
        else        begin e_rv1 = 1; e_rd1 = ref_read(a); end
      end else if (a == LED_ADDR) rled = d;
      else rmem[a[9:2]] = d;
      if (lk && hold + 1 < MAX_LOCK) begin
        owner = g; hold = hold + 1;
      end else begin
        e_to = lk; owner = -1; hold = 0;
      end
    end else if ((owner == 0 && !m0_req && !m0_lock) || (owner == 1 && !m1_req && !m1_lock)) begin
      owner = -1; hold = 0;
    end
    @(negedge clk);
  endtask

  task automatic set0(input logic r, input logic w, input logic l, input logic [31:0] a, input logic [31:0] d);
    m0_req = r; m0_we = w; m0_lock = l; m0_addr = a; m0_wdata = d;
  endtask

  task automatic set1(input logic r, input logic w, input logic l, input logic [31:0] a, input logic [31:0] d);
    m1_req = r; m1_we = w; m1_lock = l; m1_addr = a; m1_wdata = d;
  endtask

  task automatic idle();
    set0(0, 0, 0, 32'd0, 32'd0);
    set1(0, 0, 0, 32'd0, 32'd0);
  endtask

  // Asserted at a negedge; released at the following negedge.
  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
    chk("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
    chk("rst_timeout", 32'(lock_timeout), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rmem[i] = init_word(i);
    rled = 32'd0;
    mem_load = 1'b1;
    reset_n = 1'b0;
    idle();
    model_reset();
    @(negedge clk);
    mem_load = 1'b0;
    do_reset();

    // Single read by m0 after reset.
    set0(1, 0, 0, 32'h4, 32'd0);
    tick();
    idle();
    chk("t1_m0_rvalid", 32'(m0_rvalid), 32'd1);
    chk("t1_m0_rdata", m0_rdata, 32'h0000_41a8);
    chk("t1_m1_rvalid", 32'(m1_rvalid), 32'd0);
    tick();

    // Both read, unlocked: grants alternate.
    do_reset();
    set0(1, 0, 0, 32'h0, 32'd0);
    set1(1, 0, 0, 32'h8, 32'd0);
    for (int i = 0; i < 4; i++) begin
      #1 chk("t2_alt", 32'(m0_gnt), 32'(i % 2 == 0));
      tick();
    end
    idle();
    tick();
    chk("t2_m0_rdata", m0_rdata, 32'h0000_0014);
    chk("t2_m1_rdata", m1_rdata, 32'h0000_3af2);

    // m1 locked write burst while m0 keeps requesting.
    set0(1, 0, 0, 32'h100, 32'd0);
    tick();
    set0(1, 0, 0, 32'h20, 32'd0);
    for (int i = 0; i < 3; i++) begin
      set1(1, 1, i < 2, 32'h10 + 32'(4 * i), 32'hA000_0000 + 32'(i));
      #1 chk("t3_m0_blocked", 32'(m0_gnt), 32'd0);
      tick();
    end
    set1(0, 0, 0, 32'd0, 32'd0);
    #1 chk("t3_m0_gnt", 32'(m0_gnt), 32'd1);
    tick();
    idle();
    tick();
    for (int i = 0; i < 3; i++) chk("t3_ram", mem[4 + i], 32'hA000_0000 + 32'(i));

    // LED register write then read back.
    set1(1, 1, 0, LED_ADDR, 32'h0000_0FFF);
    tick();
    idle();
    chk("t5_led", led, 32'h0000_0FFF);
    set0(1, 0, 0, LED_ADDR, 32'd0);
    tick();
    idle();
    chk("t5_m0_rdata", m0_rdata, 32'h0000_0FFF);
    tick();

    // Lock held past the limit is broken after MAX_LOCK grants.
    set0(1, 0, 0, 32'h0, 32'd0);
    tick();
    for (int i = 0; i <= MAX_LOCK; i++) begin
      set1(1, 1, 1, 32'h40, 32'(i));
      #1;
      if (i < MAX_LOCK) chk("t4_m1_gnt", 32'(m1_gnt), 32'd1);
      else begin
        chk("t4_m0_gnt", 32'(m0_gnt), 32'd1);
        chk("t4_timeout", 32'(lock_timeout), 32'd1);
      end
      tick();
    end
    idle();
    tick();

    // Reset in the cycle after a read was accepted.
    set0(1, 0, 0, 32'h8, 32'd0);
    tick();
    chk("t6_rv_pre", 32'(m0_rvalid), 32'd1);
    do_reset();
    chk("t6_rv_hold", 32'(m0_rvalid), 32'd0);
    set0(1, 0, 0, 32'h0, 32'd0);
    set1(1, 0, 0, 32'h8, 32'd0);
    #1 chk("t6_tie", 32'(m0_gnt), 32'd1);
    tick();
    idle();
    tick();

    // Randomized traffic with phases of heavy locking.
    for (int c = 0; c < 1500; c++) begin
      int lock_pct;
      lock_pct = ((c / 150) % 2 == 1) ? 90 : 20;
      set0($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 99) < lock_pct,
           ($urandom_range(0, 15) == 0) ? LED_ADDR : {22'd0, 8'($urandom_range(0, 255)), 2'b00},
           $urandom);
      set1($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 99) < lock_pct,
           ($urandom_range(0, 15) == 0) ? LED_ADDR : {22'd0, 8'($urandom_range(0, 255)), 2'b00},
           $urandom);
      tick();
    end
    idle();
    // Release any lock still held by letting the owner drop its request and lock.
    tick();
    tick();
    chk("final_led", led, rled);
    for (int i = 0; i < 256; i++) chk("final_ram", mem[i], rmem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
